// File: rtl/ign_en_sequencer_if.sv
// Avalon-MM slave bus bundle for the ignition-enable sequencer.
interface ign_en_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/ign_en_sequencer.sv
// Ignition-enable gate: two-word unlock key, arm request, pre-enable delay, then a
// software watchdog. External faults and watchdog expiry latch a fault that software
// must clear explicitly.
module ign_en_sequencer #(
    parameter int unsigned ARM_DELAY   = 1000,
    parameter int unsigned WDOG_CYCLES = 50000,
    parameter int unsigned KEY_WINDOW  = 256,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    ign_en_sequencer_if.slave   bus,
    input  logic                fault_in,
    output logic                ign_en,
    output logic                irq
);

    typedef enum logic [2:0] {
        StLocked   = 3'd0,
        StKey1     = 3'd1,
        StUnlocked = 3'd2,
        StDelay    = 3'd3,
        StEnabled  = 3'd4,
        StFault    = 3'd5
    } state_e;

    localparam logic [31:0]      KEY_WORD1   = 32'h0000_00A5;
    localparam logic [31:0]      KEY_WORD2   = 32'h0000_005A;
    localparam logic [CNT_W-1:0] KEY_RELOAD  = CNT_W'(KEY_WINDOW);
    localparam logic [CNT_W-1:0] ARM_RELOAD  = CNT_W'(ARM_DELAY - 1);
    localparam logic [CNT_W-1:0] WDOG_RELOAD = CNT_W'(WDOG_CYCLES - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             fault_latched;
    logic             cause_ext;
    logic             cause_wdog;
    logic             fault_meta;
    logic             fault_s;

    logic wr, ctrl_wr, key_wr, kick_wr;
    logic arm, disarm, clear;
    logic cnt_zero;

    assign wr       = bus.chipselect & ~bus.write_n;
    assign ctrl_wr  = wr && (bus.address == 2'd0);
    assign key_wr   = wr && (bus.address == 2'd1);
    assign kick_wr  = wr && (bus.address == 2'd2);
    assign arm      = ctrl_wr & bus.writedata[0];
    assign disarm   = ctrl_wr & bus.writedata[1];
    assign clear    = ctrl_wr & bus.writedata[2];
    assign cnt_zero = (cnt == '0);

    assign irq = fault_latched;

    // Two-flop synchronizer for the asynchronous external fault input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_meta <= 1'b0;
            fault_s    <= 1'b0;
        end else begin
            fault_meta <= fault_in;
            fault_s    <= fault_meta;
        end
    end

    // Sequencer FSM with registered ign_en and fault flags; branch order is event priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StLocked;
            cnt           <= '0;
            ign_en        <= 1'b0;
            fault_latched <= 1'b0;
            cause_ext     <= 1'b0;
            cause_wdog    <= 1'b0;
        end else if (fault_s) begin
            state         <= StFault;
            cnt           <= '0;
            ign_en        <= 1'b0;
            fault_latched <= 1'b1;
            cause_ext     <= 1'b1;
        end else if (state == StEnabled && cnt_zero && !kick_wr) begin
            // A kick landing on the expiry cycle still counts as in time.
            state         <= StFault;
            cnt           <= '0;
            ign_en        <= 1'b0;
            fault_latched <= 1'b1;
            cause_wdog    <= 1'b1;
        end else if (disarm && state != StFault) begin
            state  <= StLocked;
            cnt    <= '0;
            ign_en <= 1'b0;
        end else begin
            unique case (state)
                StLocked: begin
                    if (key_wr && bus.writedata == KEY_WORD1) begin
                        state <= StKey1;
                        cnt   <= KEY_RELOAD;
                    end
                end
                StKey1: begin
                    if (key_wr) begin
                        if (bus.writedata == KEY_WORD2) begin
                            state <= StUnlocked;
                            cnt   <= KEY_RELOAD;
                        end else begin
                            state <= StLocked;
                            cnt   <= '0;
                        end
                    end else if (cnt_zero) begin
                        state <= StLocked;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StUnlocked: begin
                    if (arm) begin
                        state <= StDelay;
                        cnt   <= ARM_RELOAD;
                    end else if (cnt_zero) begin
                        state <= StLocked;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StDelay: begin
                    if (cnt_zero) begin
                        state  <= StEnabled;
                        cnt    <= WDOG_RELOAD;
                        ign_en <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StEnabled: begin
                    // Expiry was handled above, so the counter is non-zero here.
                    if (kick_wr) begin
                        cnt <= WDOG_RELOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StFault: begin
                    // fault_s is known low in this branch.
                    if (clear) begin
                        state         <= StLocked;
                        fault_latched <= 1'b0;
                        cause_ext     <= 1'b0;
                        cause_wdog    <= 1'b0;
                    end
                end
                default: begin
                    state  <= StLocked;
                    cnt    <= '0;
                    ign_en <= 1'b0;
                end
            endcase
        end
    end

    // Zero-wait-state register readback.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata = {31'b0, ign_en};
            2'd1:    bus.readdata = '0;
            2'd2:    bus.readdata = 32'(cnt);
            default: bus.readdata = {26'b0, cause_wdog, cause_ext, fault_latched, state};
        endcase
    end

endmodule

// File: tb/tb_ign_en_sequencer.sv
// Bench for ign_en_sequencer: directed steps plus a randomized phase, checked against a
// deadline-based reference model evaluated every clock.
module tb_ign_en_sequencer;

    localparam int unsigned ARM_DELAY   = 10;
    localparam int unsigned WDOG_CYCLES = 20;
    localparam int unsigned KEY_WINDOW  = 16;
    localparam int unsigned CNT_W       = 32;

    localparam int S_LOCKED   = 0;
    localparam int S_KEY1     = 1;
    localparam int S_UNLOCKED = 2;
    localparam int S_DELAY    = 3;
    localparam int S_ENABLED  = 4;
    localparam int S_FAULT    = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic fault_in = 1'b0;
    logic ign_en;
    logic irq;

    ign_en_sequencer_if bus();

    ign_en_sequencer #(
        .ARM_DELAY   (ARM_DELAY),
        .WDOG_CYCLES (WDOG_CYCLES),
        .KEY_WINDOW  (KEY_WINDOW),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .fault_in (fault_in),
        .ign_en   (ign_en),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: timed states carry an absolute deadline edge number.
    int     m_st;
    longint m_cyc;
    longint m_dl;
    bit     m_fl, m_ce, m_cw;
    bit     m_s1, m_s2;

    function automatic void model_reset();
        m_st  = S_LOCKED;
        m_cyc = 0;
        m_dl  = 0;
        m_fl  = 0;
        m_ce  = 0;
        m_cw  = 0;
        m_s1  = 0;
        m_s2  = 0;
    endfunction

    function automatic logic [31:0] model_cnt();
        if (m_st == S_KEY1 || m_st == S_UNLOCKED || m_st == S_DELAY || m_st == S_ENABLED)
            return 32'(m_dl - 1 - m_cyc);
        return 32'd0;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {31'b0, m_st == S_ENABLED};
            2'd1:    return 32'd0;
            2'd2:    return model_cnt();
            default: return {26'b0, m_cw, m_ce, m_fl, 3'(m_st)};
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    function automatic void model_edge();
        bit wr, ctrl, key, kick, fs;
        logic [31:0] d;
        wr   = bus.chipselect && !bus.write_n;
        ctrl = wr && bus.address == 2'd0;
        key  = wr && bus.address == 2'd1;
        kick = wr && bus.address == 2'd2;
        d    = bus.writedata;
        fs   = m_s2;
        m_s2 = m_s1;
        m_s1 = fault_in;
        m_cyc++;
        if (fs) begin
            m_st = S_FAULT; m_fl = 1; m_ce = 1;
        end else if (m_st == S_ENABLED && m_cyc == m_dl && !kick) begin
            m_st = S_FAULT; m_fl = 1; m_cw = 1;
        end else if (ctrl && d[1] && m_st != S_FAULT) begin
            m_st = S_LOCKED;
        end else begin
            case (m_st)
                S_LOCKED:
                    if (key && d == 32'hA5) begin m_st = S_KEY1; m_dl = m_cyc + KEY_WINDOW + 1; end
                S_KEY1:
                    if (key) begin
                        if (d == 32'h5A) begin m_st = S_UNLOCKED; m_dl = m_cyc + KEY_WINDOW + 1; end
                        else m_st = S_LOCKED;
                    end else if (m_cyc == m_dl) m_st = S_LOCKED;
                S_UNLOCKED:
                    if (ctrl && d[0]) begin m_st = S_DELAY; m_dl = m_cyc + ARM_DELAY; end
                    else if (m_cyc == m_dl) m_st = S_LOCKED;
                S_DELAY:
                    if (m_cyc == m_dl) begin m_st = S_ENABLED; m_dl = m_cyc + WDOG_CYCLES; end
                S_ENABLED:
                    if (kick) m_dl = m_cyc + WDOG_CYCLES;
                default:
                    if (ctrl && d[2]) begin m_st = S_LOCKED; m_fl = 0; m_ce = 0; m_cw = 0; end
            endcase
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: model and DUT step together, outputs compared at the falling edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("ign_en", 32'(ign_en), 32'(m_st == S_ENABLED));
        check("irq", 32'(irq), 32'(m_fl));
        check("readdata", bus.readdata, model_read(bus.address));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.address = 2'($urandom_range(0, 3));
            cycle();
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        cycle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.address = a;
        #1;
        check(tag, bus.readdata, exp);
    endtask

    task automatic goto_enabled();
        bus_write(2'd1, 32'hA5);
        bus_write(2'd1, 32'h5A);
        bus_write(2'd0, 32'h1);
        idle(ARM_DELAY);
        check("goto_enabled", 32'(ign_en), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat;
        int r;
        logic [31:0] d;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = '0;
        model_reset();

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_ign_en", 32'(ign_en), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        read_chk("rst_status", 2'd3, 32'd0);
        read_chk("rst_cnt", 2'd2, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Nominal unlock and arm.
        bus_write(2'd1, 32'hA5);
        read_chk("key1_state", 2'd3, S_KEY1);
        read_chk("key1_cnt", 2'd2, KEY_WINDOW);
        bus_write(2'd1, 32'h5A);
        read_chk("unlocked_state", 2'd3, S_UNLOCKED);
        bus_write(2'd0, 32'h1);
        lat = 0;
        while (!ign_en && lat < 50) begin cycle(); lat++; end
        check("arm_latency", lat, ARM_DELAY);
        read_chk("enabled_status", 2'd3, S_ENABLED);

        // Regular kicks hold ignition on; stopping them trips the watchdog.
        for (int k = 0; k < 13; k++) begin
            bus_write(2'd2, $urandom);
            idle(14);
        end
        check("wdog_hold", 32'(ign_en), 32'd1);
        bus_write(2'd2, 32'd0);
        lat = 0;
        while (!irq && lat < 100) begin cycle(); lat++; end
        check("wdog_latency", lat, WDOG_CYCLES);
        check("wdog_ign_off", 32'(ign_en), 32'd0);
        read_chk("wdog_status", 2'd3, 32'h2D);
        bus_write(2'd0, 32'h4);
        read_chk("wdog_cleared", 2'd3, 32'd0);

        // Bad second key word, then a key window timeout.
        bus_write(2'd1, 32'hA5);
        bus_write(2'd1, 32'h5B);
        bus_write(2'd0, 32'h1);
        read_chk("badkey_status", 2'd3, S_LOCKED);
        check("badkey_ign", 32'(ign_en), 32'd0);
        bus_write(2'd1, 32'hA5);
        idle(KEY_WINDOW);
        read_chk("keywin_last", 2'd3, S_KEY1);
        idle(1);
        read_chk("keywin_expired", 2'd3, S_LOCKED);

        // External fault: off by the third edge, clear blocked while asserted.
        goto_enabled();
        fault_in = 1'b1;
        idle(2);
        check("ext_ign_2edges", 32'(ign_en), 32'd1);
        idle(1);
        check("ext_ign_3edges", 32'(ign_en), 32'd0);
        read_chk("ext_status", 2'd3, 32'h1D);
        bus_write(2'd0, 32'h4);
        read_chk("ext_clear_blocked", 2'd3, 32'h1D);
        fault_in = 1'b0;
        idle(2);
        bus_write(2'd0, 32'h4);
        read_chk("ext_cleared", 2'd3, 32'd0);
        check("ext_irq_low", 32'(irq), 32'd0);

        // ARM and DISARM together: DISARM wins.
        bus_write(2'd1, 32'hA5);
        bus_write(2'd1, 32'h5A);
        bus_write(2'd0, 32'h3);
        read_chk("arm_disarm", 2'd3, S_LOCKED);

        // Kick exactly on the expiry cycle.
        goto_enabled();
        idle(WDOG_CYCLES - 1);
        read_chk("cnt_at_expiry", 2'd2, 32'd0);
        bus_write(2'd2, 32'd0);
        read_chk("kick_on_expiry", 2'd3, S_ENABLED);
        read_chk("kick_reload", 2'd2, WDOG_CYCLES - 1);

        // DISARM during the pre-enable delay.
        bus_write(2'd0, 32'h2);
        bus_write(2'd1, 32'hA5);
        bus_write(2'd1, 32'h5A);
        bus_write(2'd0, 32'h1);
        idle(3);
        bus_write(2'd0, 32'h2);
        read_chk("disarm_delay", 2'd3, S_LOCKED);
        idle(ARM_DELAY + 2);
        check("disarm_no_ign", 32'(ign_en), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                bus_write(2'd1, 32'hA5);
                bus_write(2'd1, 32'h5A);
                bus_write(2'd0, 32'h1);
            end else if (r < 30) begin
                case ($urandom_range(0, 7))
                    0: d = 32'hA5;
                    1: d = 32'h5A;
                    2: d = 32'h1;
                    3: d = 32'h2;
                    4: d = 32'h4;
                    5: d = 32'h3;
                    6: d = $urandom;
                    default: d = 32'h0;
                endcase
                bus_write(2'($urandom_range(0, 3)), d);
            end else begin
                idle(1);
            end
            if ($urandom_range(0, 299) == 0) fault_in = 1'b1;
            else if (fault_in && $urandom_range(0, 3) == 0) fault_in = 1'b0;
        end
        fault_in = 1'b0;
        idle(3);
        bus_write(2'd0, 32'h4);
        read_chk("rand_end", 2'd3, model_read(2'd3));

        // Asynchronous reset from ENABLED.
        bus_write(2'd0, 32'h2);
        goto_enabled();
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_ign", 32'(ign_en), 32'd0);
        check("async_rst_irq", 32'(irq), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        read_chk("post_rst_status", 2'd3, S_LOCKED);
        bus_write(2'd0, 32'h1);
        read_chk("arm_no_key", 2'd3, S_LOCKED);
        check("arm_no_key_ign", 32'(ign_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
